// File: rtl/pi_seq_cntrl.sv
// Sequences two A2D conversions, then steps the shared ALU through the PI microprogram.
// Latency: 14 cycles go->done, counting the go cycle in IDLE, when each conversion completes in one cycle.
// Backpressure: waits in WAIT_A/WAIT_B for cnv_cmplt. go is sampled only in IDLE; a go while busy is dropped.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   go                  start one control cycle (sampled only in IDLE)
//   cnv_cmplt, a2d_res  A2D handshake and result (the result feeds the ALU directly)
//   dst                 ALU result, captured into the state registers
//   strt_cnv, chnnl     A2D start pulse and channel select
//   src1sel, src0sel    ALU operand selects
//   multiply, sub, mult2, mult4, saturate   ALU op flags
//   accum, pcomp, error, intgrl, icomp      state registers fed back to the ALU
//   lft, rht            motor outputs, held between updates
//   busy, done          busy outside IDLE; done pulses in the cycle lft is written
module pi_seq_cntrl #(
  parameter logic [2:0] CH_A      = 3'd0,
  parameter logic [2:0] CH_B      = 3'd1,
  parameter int         INT_DEC_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] a2d_res,
  input  logic [15:0] dst,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [2:0]  src1sel,
  output logic [2:0]  src0sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [15:0] accum,
  output logic [15:0] pcomp,
  output logic [11:0] error,
  output logic [11:0] intgrl,
  output logic [11:0] icomp,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        busy,
  output logic        done
);

  // ALU src1 operand encodings
  localparam logic [2:0] S1_ACCUM = 3'd0;
  localparam logic [2:0] S1_ITERM = 3'd1;
  localparam logic [2:0] S1_ERROR = 3'd2;
  localparam logic [2:0] S1_ERRS4 = 3'd3;
  localparam logic [2:0] S1_FWD   = 3'd4;

  // ALU src0 operand encodings
  localparam logic [2:0] S0_A2D    = 3'd0;
  localparam logic [2:0] S0_INTGRL = 3'd1;
  localparam logic [2:0] S0_ICOMP  = 3'd2;
  localparam logic [2:0] S0_PCOMP  = 3'd3;
  localparam logic [2:0] S0_PTERM  = 3'd4;

  localparam logic [INT_DEC_W-1:0] DEC_ONE = {{(INT_DEC_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CNV_A  = 4'd1,
    WAIT_A = 4'd2,
    ACC_A  = 4'd3,
    CNV_B  = 4'd4,
    WAIT_B = 4'd5,
    ERR    = 4'd6,
    INTG   = 4'd7,
    ICMP   = 4'd8,
    PCMP   = 4'd9,
    RHT0   = 4'd10,
    RHT    = 4'd11,
    LFT0   = 4'd12,
    LFT    = 4'd13
  } state_t;

  state_t state, nxt_state;

  // Register-load strobes decoded from the current state
  logic clr_accum;
  logic ld_accum;
  logic ld_error;
  logic ld_intgrl;
  logic ld_icomp;
  logic ld_pcomp;
  logic ld_rht;
  logic ld_lft;
  logic inc_dec;

  logic [INT_DEC_W-1:0] dec_cnt;

  // a2d_res is wired straight into the ALU; the sequencer never looks at it.
  logic unused_a2d;
  assign unused_a2d = ^a2d_res;

  // ---------------------------------------------------------------------------
  // Next state, ALU controls and register strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_state = state;
    strt_cnv  = 1'b0;
    chnnl     = 3'd0;
    src1sel   = S1_ACCUM;
    src0sel   = S0_A2D;
    multiply  = 1'b0;
    sub       = 1'b0;
    mult2     = 1'b0;
    mult4     = 1'b0;
    saturate  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    clr_accum = 1'b0;
    ld_accum  = 1'b0;
    ld_error  = 1'b0;
    ld_intgrl = 1'b0;
    ld_icomp  = 1'b0;
    ld_pcomp  = 1'b0;
    ld_rht    = 1'b0;
    ld_lft    = 1'b0;
    inc_dec   = 1'b0;

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) begin
          clr_accum = 1'b1;
          nxt_state = CNV_A;
        end
      end
      CNV_A: begin
        strt_cnv  = 1'b1;
        chnnl     = CH_A;
        nxt_state = WAIT_A;
      end
      WAIT_A: begin
        chnnl = CH_A;
        if (cnv_cmplt) nxt_state = ACC_A;
      end
      ACC_A: begin
        src1sel   = S1_ACCUM;
        src0sel   = S0_A2D;
        ld_accum  = 1'b1;
        nxt_state = CNV_B;
      end
      CNV_B: begin
        strt_cnv  = 1'b1;
        chnnl     = CH_B;
        nxt_state = WAIT_B;
      end
      WAIT_B: begin
        chnnl = CH_B;
        if (cnv_cmplt) nxt_state = ERR;
      end
      ERR: begin
        src1sel   = S1_ACCUM;
        src0sel   = S0_A2D;
        sub       = 1'b1;
        saturate  = 1'b1;
        ld_error  = 1'b1;
        nxt_state = INTG;
      end
      INTG: begin
        // Integrator is decimated: the sum is formed every run but only
        // committed when the decimation counter is all ones.
        src1sel   = S1_ERRS4;
        src0sel   = S0_INTGRL;
        saturate  = 1'b1;
        ld_intgrl = &dec_cnt;
        nxt_state = ICMP;
      end
      ICMP: begin
        src1sel   = S1_ITERM;
        src0sel   = S0_INTGRL;
        multiply  = 1'b1;
        saturate  = 1'b1;
        ld_icomp  = 1'b1;
        nxt_state = PCMP;
      end
      PCMP: begin
        src1sel   = S1_ERROR;
        src0sel   = S0_PTERM;
        multiply  = 1'b1;
        ld_pcomp  = 1'b1;
        nxt_state = RHT0;
      end
      RHT0: begin
        src1sel   = S1_FWD;
        src0sel   = S0_PCOMP;
        sub       = 1'b1;
        ld_accum  = 1'b1;
        nxt_state = RHT;
      end
      RHT: begin
        src1sel   = S1_ACCUM;
        src0sel   = S0_ICOMP;
        sub       = 1'b1;
        saturate  = 1'b1;
        ld_rht    = 1'b1;
        nxt_state = LFT0;
      end
      LFT0: begin
        src1sel   = S1_FWD;
        src0sel   = S0_PCOMP;
        ld_accum  = 1'b1;
        nxt_state = LFT;
      end
      LFT: begin
        src1sel   = S1_ACCUM;
        src0sel   = S0_ICOMP;
        saturate  = 1'b1;
        ld_lft    = 1'b1;
        inc_dec   = 1'b1;
        done      = 1'b1;
        nxt_state = IDLE;
      end
      default: begin
        busy      = 1'b0;
        nxt_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      accum   <= 16'd0;
      pcomp   <= 16'd0;
      error   <= 12'd0;
      intgrl  <= 12'd0;
      icomp   <= 12'd0;
      lft     <= 12'd0;
      rht     <= 12'd0;
      dec_cnt <= '0;
    end else begin
      state <= nxt_state;

      if (clr_accum)     accum <= 16'd0;
      else if (ld_accum) accum <= dst;

      if (ld_error)  error  <= dst[11:0];
      if (ld_intgrl) intgrl <= dst[11:0];
      if (ld_icomp)  icomp  <= dst[11:0];
      if (ld_pcomp)  pcomp  <= dst;
      if (ld_rht)    rht    <= dst[11:0];
      if (ld_lft)    lft    <= dst[11:0];

      // Free-running wrap; counts completed runs only (an aborted run does not count).
      if (inc_dec) dec_cnt <= dec_cnt + DEC_ONE;
    end
  end

endmodule

// File: tb/tb_pi_seq_cntrl.sv
module tb_pi_seq_cntrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        cnv_cmplt;
  logic [11:0] a2d_res;
  logic [15:0] dst;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [2:0]  src1sel;
  logic [2:0]  src0sel;
  logic        multiply, sub, mult2, mult4, saturate;
  logic [15:0] accum, pcomp;
  logic [11:0] error, intgrl, icomp, lft, rht;
  logic        busy, done;

  always #5 clk = ~clk;

  pi_seq_cntrl dut (
    .clk(clk), .rst(rst), .go(go), .cnv_cmplt(cnv_cmplt), .a2d_res(a2d_res), .dst(dst),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .src1sel(src1sel), .src0sel(src0sel),
    .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4), .saturate(saturate),
    .accum(accum), .pcomp(pcomp), .error(error), .intgrl(intgrl), .icomp(icomp),
    .lft(lft), .rht(rht), .busy(busy), .done(done)
  );

  // ---------------- environment: ALU constants and A2D values ----------------
  logic signed [15:0] iterm, pterm, fwd;
  logic [11:0] a_val, b_val;
  int          dly;

  // ---------------- ALU model ----------------
  logic signed [31:0] s1, s0, wide;
  always_comb begin
    s1 = 32'sd0;
    s0 = 32'sd0;
    case (src1sel)
      3'd0: s1 = $signed({{16{accum[15]}}, accum});
      3'd1: s1 = $signed({{16{iterm[15]}}, iterm});
      3'd2: s1 = $signed({{20{error[11]}}, error});
      3'd3: s1 = $signed({{20{error[11]}}, error}) >>> 4;
      3'd4: s1 = $signed({{16{fwd[15]}}, fwd});
      default: s1 = 32'sd0;
    endcase
    case (src0sel)
      3'd0: s0 = $signed({20'd0, a2d_res});
      3'd1: s0 = $signed({{20{intgrl[11]}}, intgrl});
      3'd2: s0 = $signed({{20{icomp[11]}}, icomp});
      3'd3: s0 = $signed({{16{pcomp[15]}}, pcomp});
      3'd4: s0 = $signed({{16{pterm[15]}}, pterm});
      default: s0 = 32'sd0;
    endcase
    if (multiply)  wide = (s1 * s0) >>> 12;
    else if (sub)  wide = s1 - s0;
    else           wide = s1 + s0;
    if (saturate && wide > 32'sd2047)       dst = 16'h07FF;
    else if (saturate && wide < -32'sd2048) dst = 16'hF800;
    else                                    dst = wide[15:0];
  end

  // ---------------- A2D model with programmable delay ----------------
  int cnt;
  always @(posedge clk) begin
    if (rst) begin
      cnv_cmplt <= 1'b0;
      a2d_res   <= 12'd0;
      cnt       <= 0;
    end else if (strt_cnv) begin
      a2d_res <= (chnnl == 3'd1) ? b_val : a_val;
      if (dly == 0) begin
        cnv_cmplt <= 1'b1;
        cnt       <= 0;
      end else begin
        cnv_cmplt <= 1'b0;
        cnt       <= dly;
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) cnv_cmplt <= 1'b1;
    end
  end

  // ---------------- monitors ----------------
  int   done_cnt, sa_cnt, sb_cnt, dbl_done;
  logic done_q;
  always @(negedge clk) begin
    if (rst) begin
      done_q = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (done && done_q) dbl_done++;
      if (strt_cnv && chnnl == 3'd0) sa_cnt++;
      if (strt_cnv && chnnl == 3'd1) sb_cnt++;
      done_q = done;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [10:0] ops;
  assign ops = {src1sel, src0sel, multiply, sub, mult2, mult4, saturate};

  logic [10:0] snap_err, snap_icmp, snap_rht0;
  logic [15:0] snap_wait;

  // Called at a negedge with the DUT idle. Returns the cycle index at which
  // done was seen (go cycle = 1); leaves the bench at the negedge after LFT.
  task automatic run(input logic [11:0] a, input logic [11:0] b, input bit hammer, output int cyc);
    bit seen;
    a_val = a;
    b_val = b;
    go    = 1'b1;
    cyc   = 1;
    seen  = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hammer) go = 1'b0;
      cyc++;
      if (cyc == 5)  snap_wait = {busy, strt_cnv, chnnl, ops};
      if (cyc == 7)  snap_err  = ops;
      if (cyc == 9)  snap_icmp = ops;
      if (cyc == 11) snap_rht0 = ops;
      if (done) seen = 1'b1;
    end
    go = 1'b0;
    check("run_timeout", {31'd0, seen}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  int lat;

  initial begin
    rst = 1'b1; go = 1'b0; dly = 0;
    a_val = 12'd0; b_val = 12'd0;
    iterm = 16'sd0; pterm = 16'sd0; fwd = 16'sh0123;
    done_cnt = 0; sa_cnt = 0; sb_cnt = 0; dbl_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state
    check("rst_ctl", {busy, done, strt_cnv, chnnl, ops}, 32'd0);
    check("rst_regs", {accum, pcomp}, 32'd0);
    check("rst_regs12", {error, intgrl, icomp}, 32'd0);
    check("rst_out", {lft, rht}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic run: error = 0x300 - 0x100, zero gains, outputs = fwd
    run(12'h300, 12'h100, 1'b0, lat);
    check("lat_min", lat, 14);
    check("err_ops", snap_err, {3'd0, 3'd0, 5'b01001});
    check("icmp_ops", snap_icmp, {3'd1, 3'd1, 5'b10001});
    check("rht0_ops", snap_rht0, {3'd4, 3'd3, 5'b01000});
    check("error1", error, 12'h200);
    check("icomp1", icomp, 12'h000);
    check("pcomp1", pcomp, 16'h0000);
    check("rht1", rht, 12'h123);
    check("lft1", lft, 12'h123);
    check("accum1", accum, 16'h0123);
    check("intgrl1", intgrl, 12'h000);
    check("idle1", {busy, done}, 32'd0);

    // integrator decimation: runs 2..8
    for (int r = 2; r <= 8; r++) begin
      run(12'h300, 12'h100, 1'b0, lat);
      check($sformatf("intgrl_run%0d", r), intgrl, (r < 4) ? 12'h000 : (r < 8) ? 12'h020 : 12'h040);
    end

    // error saturation, and lft/rht saturating on a large fwd
    fwd = 16'sh0900;
    run(12'h000, 12'hFFF, 1'b0, lat);
    check("err_negsat", error, 12'h800);
    check("rht_sat", rht, 12'h7FF);
    check("lft_sat", lft, 12'h7FF);
    run(12'hFFF, 12'h000, 1'b0, lat);
    check("err_possat", error, 12'h7FF);
    check("intgrl_hold", intgrl, 12'h040);

    // slow conversions: 20-cycle delay on each channel
    fwd = 16'sh0123;
    dly = 20;
    sa_cnt = 0; sb_cnt = 0; done_cnt = 0;
    run(12'h300, 12'h100, 1'b0, lat);
    check("wait_a_hold", snap_wait, {1'b1, 1'b0, 3'd0, 11'd0});
    check("lat_slow", lat, 54);
    check("strt_a_cnt", sa_cnt, 1);
    check("strt_b_cnt", sb_cnt, 1);
    check("done_slow", done_cnt, 1);
    check("error_slow", error, 12'h200);

    // reset while waiting on channel B
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    begin
      bit in_wb;
      in_wb = 1'b0;
      for (int i = 0; i < 200 && !in_wb; i++) begin
        @(negedge clk);
        if (busy && !strt_cnv && chnnl == 3'd1) in_wb = 1'b1;
      end
      check("reach_wait_b", {31'd0, in_wb}, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstwb_ctl", {busy, strt_cnv, done}, 32'd0);
    check("rstwb_regs", {accum, pcomp}, 32'd0);
    check("rstwb_regs12", {error, intgrl, icomp}, 32'd0);
    check("rstwb_out", {lft, rht}, 32'd0);
    rst = 1'b0;
    dly = 0;
    @(negedge clk);

    // decimation counter must restart from zero after reset
    for (int r = 1; r <= 4; r++) begin
      run(12'h300, 12'h100, 1'b0, lat);
      check($sformatf("intgrl_post_rst%0d", r), intgrl, (r < 4) ? 12'h000 : 12'h020);
    end
    check("lat_post_rst", lat, 14);

    // go held every cycle of a run: one done, one cycle wide, busy drops after
    done_cnt = 0; dbl_done = 0;
    run(12'h300, 12'h100, 1'b1, lat);
    check("hammer_idle", {busy, done}, 32'd0);
    repeat (4) @(negedge clk);
    check("hammer_done_cnt", done_cnt, 1);
    check("hammer_done_width", dbl_done, 0);
    check("hammer_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
